// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU op classes, ID/EX control-bit positions and R-type funct codes.
package mips_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_MEM_READ   = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 4;
  localparam int unsigned CTRL_BRANCH     = 3;
  localparam int unsigned CTRL_ALU_SRC    = 2;
  localparam int unsigned CTRL_REG_DST    = 1;
  localparam int unsigned CTRL_JUMP       = 0;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rt);
    rt_match = id_uses_rt && (id_rt == ex_rt);
    // $0 is hardwired to zero, so a load targeting it can never feed a dependent.
    load_use = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold priority and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [7:0]        id_ctrl,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [7:0]        ex_ctrl,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // Gated by rst so a hold request cannot leak a stall while the pipe is in reset.
  assign stall_o = (load_use || hold_i) && !flush_i && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_alu_op  <= '0;
      ex_funct   <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      bubble_cnt <= '0;
    end else if (flush_i || (!hold_i && load_use)) begin
      // Flush and bubble share the clear path; only a bubble (hold low, no flush) bumps the counter.
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_alu_op  <= '0;
      ex_funct   <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      if (!flush_i && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (!hold_i) begin
      ex_valid  <= id_valid;
      ex_ctrl   <= id_ctrl;
      ex_alu_op <= id_alu_op;
      ex_funct  <= id_imm[5:0];
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, counter saturation sequence, randomized model comparison.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [7:0]  id_ctrl;
  logic [1:0]  id_alu_op;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, flush_i, hold_i;

  logic        stall_o, ex_valid;
  logic [7:0]  ex_ctrl;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_valid;
  logic [7:0]  s_ctrl;
  logic [1:0]  s_alu_op;
  logic [5:0]  s_funct;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [2:0]  s_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation in a few cycles.
  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(s_stall), .ex_valid(s_valid), .ex_ctrl(s_ctrl), .ex_alu_op(s_alu_op), .ex_funct(s_funct),
    .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic fl, ho, v;
    logic [7:0] c;
    logic [1:0] op;
    logic [31:0] r1, r2, im;
    logic [4:0] rs, rt;
    logic urs, urt;
    logic e_st, e_v;
    logic [7:0] e_c;
    logic [1:0] e_op;
    logic [5:0] e_f;
    logic [31:0] e_r1, e_r2;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic fl, logic ho, logic v, logic [7:0] c, logic [1:0] op,
                              logic [31:0] r1, logic [31:0] r2, logic [31:0] im,
                              logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic e_st, logic e_v, logic [7:0] e_c, logic [1:0] e_op,
                              logic [5:0] e_f, logic [31:0] e_r1, logic [31:0] e_r2, logic [15:0] e_cnt);
    vec_t t;
    t.fl = fl; t.ho = ho; t.v = v; t.c = c; t.op = op; t.r1 = r1; t.r2 = r2; t.im = im;
    t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.e_st = e_st; t.e_v = e_v; t.e_c = e_c; t.e_op = e_op; t.e_f = e_f;
    t.e_r1 = e_r1; t.e_r2 = e_r2; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input vec_t t, input logic [4:0] rd);
    flush_i = t.fl; hold_i = t.ho; id_valid = t.v; id_ctrl = t.c; id_alu_op = t.op;
    id_rd1 = t.r1; id_rd2 = t.r2; id_imm = t.im; id_rs = t.rs; id_rt = t.rt; id_rd = rd;
    id_uses_rs = t.urs; id_uses_rt = t.urt;
  endtask

  task automatic do_reset();
    vec_t z;
    z = mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0);
    drive(z, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural model of the EX-side register contents.
  logic        m_v;
  logic [7:0]  m_c;
  logic [1:0]  m_op;
  logic [31:0] m_r1, m_r2, m_im;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt, m_cnt_s;

  function automatic logic model_hazard(input vec_t t);
    logic dep;
    dep = (t.urs && t.rs == m_rt) || (t.urt && t.rt == m_rt);
    return m_v && m_c[5] && (m_rt != 0) && t.v && dep;
  endfunction

  task automatic model_edge(input vec_t t, input logic [4:0] rd, input logic hz);
    if (t.fl || (!t.ho && hz)) begin
      m_v = 0; m_c = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_im = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      if (!t.fl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
      end
    end else if (!t.ho) begin
      m_v = t.v; m_c = t.c; m_op = t.op; m_r1 = t.r1; m_r2 = t.r2; m_im = t.im;
      m_rs = t.rs; m_rt = t.rt; m_rd = rd;
    end
  endtask

  vec_t tbl[$];
  vec_t lw8, add8;

  initial begin
    rst = 1'b1;
    #2;
    chk("reset_valid", ex_valid, 0);
    chk("reset_stall", stall_o, 0);
    chk("reset_cnt", bubble_cnt, 0);
    @(negedge clk);
    do_reset();

    //         fl ho v  ctrl  op r1  r2  imm    rs rt urs urt | st v ctrl  op funct r1  r2  cnt
    tbl.push_back(mk(0,0,1,8'h80,2,  5,  7,32'h2A, 1,2,1,1,  0,1,8'h80,2,6'h2A,  5,  7,0));
    tbl.push_back(mk(0,0,1,8'hE4,0,100,102,32'h04, 9,8,1,0,  0,1,8'hE4,0,6'h04,100,102,0));
    tbl.push_back(mk(0,0,1,8'h80,2, 11, 13,32'h20, 8,3,1,0,  1,0,8'h00,0,6'h00,  0,  0,1));
    tbl.push_back(mk(0,0,1,8'h80,2, 11, 13,32'h20, 8,3,1,0,  0,1,8'h80,2,6'h20, 11, 13,1));
    tbl.push_back(mk(0,0,1,8'hE4,0, 22, 24,32'h08, 3,0,1,0,  0,1,8'hE4,0,6'h08, 22, 24,1));
    tbl.push_back(mk(0,0,1,8'h80,2, 33, 35,32'h22, 0,4,1,0,  0,1,8'h80,2,6'h22, 33, 35,1));
    tbl.push_back(mk(0,0,1,8'hE4,0, 44, 46,32'h00, 1,8,1,0,  0,1,8'hE4,0,6'h00, 44, 46,1));
    tbl.push_back(mk(1,0,1,8'h80,2, 50, 52,32'h20, 8,3,1,0,  0,0,8'h00,0,6'h00,  0,  0,1));
    tbl.push_back(mk(0,0,1,8'hE4,0, 55, 57,32'h10, 1,8,1,0,  0,1,8'hE4,0,6'h10, 55, 57,1));
    tbl.push_back(mk(0,1,1,8'h80,2, 66, 68,32'h24, 8,3,1,0,  1,1,8'hE4,0,6'h10, 55, 57,1));
    tbl.push_back(mk(0,1,1,8'h80,2, 66, 68,32'h24, 8,3,1,0,  1,1,8'hE4,0,6'h10, 55, 57,1));
    tbl.push_back(mk(0,1,1,8'h80,2, 66, 68,32'h24, 8,3,1,0,  1,1,8'hE4,0,6'h10, 55, 57,1));
    tbl.push_back(mk(0,0,1,8'h80,2, 66, 68,32'h24, 8,3,1,0,  1,0,8'h00,0,6'h00,  0,  0,2));
    tbl.push_back(mk(0,0,1,8'h80,2, 66, 68,32'h24, 8,3,1,0,  0,1,8'h80,2,6'h24, 66, 68,2));
    tbl.push_back(mk(0,0,1,8'hE4,0, 77, 79,32'h01, 1,5,1,0,  0,1,8'hE4,0,6'h01, 77, 79,2));
    tbl.push_back(mk(0,0,1,8'h80,2, 88, 90,32'h25, 5,7,0,1,  0,1,8'h80,2,6'h25, 88, 90,2));
    tbl.push_back(mk(0,0,1,8'hE4,0, 91, 93,32'h02, 1,9,1,0,  0,1,8'hE4,0,6'h02, 91, 93,2));
    tbl.push_back(mk(0,0,0,8'h00,0, 99,101,32'h3F, 9,9,1,1,  0,0,8'h00,0,6'h3F, 99,101,2));
    tbl.push_back(mk(0,0,1,8'hE4,0, 12, 14,32'h03, 1,9,1,0,  0,1,8'hE4,0,6'h03, 12, 14,2));
    tbl.push_back(mk(0,0,1,8'h80,2, 13, 15,32'h2A, 2,9,0,1,  1,0,8'h00,0,6'h00,  0,  0,3));
    tbl.push_back(mk(0,0,1,8'h80,2, 13, 15,32'h2A, 2,9,0,1,  0,1,8'h80,2,6'h2A, 13, 15,3));
    tbl.push_back(mk(0,0,1,8'hE4,0, 20, 22,32'h00, 1,8,1,0,  0,1,8'hE4,0,6'h00, 20, 22,3));
    tbl.push_back(mk(1,1,1,8'h80,2,  1,  3,32'h00, 8,0,1,0,  0,0,8'h00,0,6'h00,  0,  0,3));
    tbl.push_back(mk(0,0,1,8'h80,2,  4,  6,32'h20, 1,2,1,1,  0,1,8'h80,2,6'h20,  4,  6,3));

    foreach (tbl[i]) begin
      drive(tbl[i], 5'd3);
      #1;
      chk($sformatf("v%0d_stall", i), stall_o, tbl[i].e_st);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), ex_valid, tbl[i].e_v);
      chk($sformatf("v%0d_ctrl", i), ex_ctrl, tbl[i].e_c);
      chk($sformatf("v%0d_aluop", i), ex_alu_op, tbl[i].e_op);
      chk($sformatf("v%0d_funct", i), ex_funct, tbl[i].e_f);
      chk($sformatf("v%0d_rd1", i), ex_rd1, tbl[i].e_r1);
      chk($sformatf("v%0d_rd2", i), ex_rd2, tbl[i].e_r2);
      chk($sformatf("v%0d_cnt", i), bubble_cnt, tbl[i].e_cnt);
      @(negedge clk);
    end

    // Asynchronous reset with a valid entry in EX and hold requested: no clock edge involved.
    hold_i = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_ctrl", ex_ctrl, 0);
    chk("async_rst_rd1", ex_rd1, 0);
    chk("async_rst_cnt", bubble_cnt, 0);
    chk("async_rst_stall", stall_o, 0);
    @(negedge clk);
    do_reset();

    // Saturation: repeated lw / dependent add pairs, 9 bubbles in total.
    lw8  = mk(0,0,1,8'hE4,0, 1,2,32'h4, 1,8,1,0, 0,0,0,0,0,0,0,0);
    add8 = mk(0,0,1,8'h80,2, 3,4,32'h20, 8,2,1,1, 0,0,0,0,0,0,0,0);
    for (int unsigned k = 0; k < 9; k++) begin
      drive(lw8, 5'd8);  @(posedge clk); @(negedge clk);
      drive(add8, 5'd9); #1;
      chk($sformatf("sat%0d_stall", k), stall_o, 1);
      @(posedge clk); @(negedge clk);
      drive(add8, 5'd9); @(posedge clk); @(negedge clk);
    end
    chk("sat_wide_cnt", bubble_cnt, 9);
    chk("sat_narrow_cnt", s_cnt, 7);

    // Randomized run against the behavioural model.
    do_reset();
    m_v = 0; m_c = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_im = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_cnt = 0; m_cnt_s = 0;
    for (int unsigned n = 0; n < 3000; n++) begin
      vec_t t;
      logic [4:0] rd;
      logic hz;
      t = mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0);
      t.fl = ($urandom_range(9) == 0);
      t.ho = ($urandom_range(7) == 0);
      t.v  = ($urandom_range(3) != 0);
      t.c  = t.v ? 8'($urandom) : 8'h00;
      t.op = 2'($urandom_range(2));
      t.r1 = $urandom; t.r2 = $urandom; t.im = $urandom;
      t.rs = 5'($urandom_range(3)); t.rt = 5'($urandom_range(3));
      t.urs = 1'($urandom); t.urt = 1'($urandom);
      rd = 5'($urandom_range(31));
      drive(t, rd);
      hz = model_hazard(t);
      #1;
      chk("rnd_stall", stall_o, (hz || t.ho) && !t.fl);
      chk("rnd_stall_narrow", s_stall, (hz || t.ho) && !t.fl);
      @(posedge clk);
      model_edge(t, rd, hz);
      #1;
      chk("rnd_valid", ex_valid, m_v);
      chk("rnd_ctrl", ex_ctrl, m_c);
      chk("rnd_aluop", ex_alu_op, m_op);
      chk("rnd_funct", ex_funct, m_im[5:0]);
      chk("rnd_rd1", ex_rd1, m_r1);
      chk("rnd_rd2", ex_rd2, m_r2);
      chk("rnd_imm", ex_imm, m_im);
      chk("rnd_rs", ex_rs, m_rs);
      chk("rnd_rt", ex_rt, m_rt);
      chk("rnd_rd", ex_rd, m_rd);
      chk("rnd_cnt", bubble_cnt, m_cnt);
      chk("rnd_cnt_narrow", s_cnt, m_cnt_s);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection, directly upstream of the Execute stage.
- Captures decoded control, register operands, immediate and register specifiers from Decode each cycle.
- Presents them to the ALU, the ALU control decoder (ex_alu_op, ex_funct) and the forwarding mux.
- Inserts bubbles on load-use hazards, honours branch flush and downstream hold, and counts inserted bubbles.

Parameters:
DATA_W, 32, width of register operands and sign-extended immediate
REG_W, 5, register specifier width
CNT_W, 16, width of saturating bubble counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  Decode holds a real instruction
id_ctrl  input  8  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, jump}
id_alu_op  input  2  ALU op class from main control
id_rd1  input  DATA_W  register file read data 1
id_rd2  input  DATA_W  register file read data 2
id_imm  input  DATA_W  sign-extended immediate
id_rs  input  REG_W  source register rs
id_rt  input  REG_W  source register rt
id_rd  input  REG_W  destination register rd
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
flush_i  input  1  branch/jump resolved taken; kill ID instruction
hold_i  input  1  downstream stage cannot accept; freeze ID/EX
stall_o  output  1  freeze PC and IF/ID this cycle
ex_valid  output  1  EX holds a real instruction
ex_ctrl  output  8  registered id_ctrl
ex_alu_op  output  2  registered id_alu_op
ex_funct  output  6  registered id_imm[5:0]
ex_rd1, ex_rd2, ex_imm  output  DATA_W each  registered operands
ex_rs, ex_rt, ex_rd  output  REG_W each  registered specifiers
bubble_cnt  output  CNT_W  load-use bubbles inserted since reset

Behaviour:
- Reset (async, rst=1): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0, stall_o = 0. Reset mid-stall clears everything immediately; first edge after deassertion is a normal load.
- Latency: one cycle, ID inputs appear on ex_* after the next rising edge.
- load_use (combinational) = ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & id_valid & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)). Register 0 never hazards.
- stall_o = (load_use | hold_i) & ~flush_i.
- Per-edge action, strict priority:
  - 1. FLUSH (flush_i): all ex_* cleared to 0, ex_valid = 0.
  - 2. HOLD (hold_i): all ex_* retain value; bubble_cnt unchanged.
  - 3. BUBBLE (load_use): all ex_* cleared to 0, ex_valid = 0; bubble_cnt += 1, saturating at all-ones.
  - 4. LOAD: ex_* <= id_*, ex_valid <= id_valid, ex_funct <= id_imm[5:0].
- Load-use stall lasts exactly one cycle: after a bubble ex_ctrl.mem_read = 0, so the instruction loads on the next edge.
- Bubble/flush clears all control bits, so no write or memory side effects.
- id_valid = 0 loads an invalid entry with its control bits as given; Decode guarantees zero control for invalid slots.
- flush_i with hold_i: flush wins (EX content is wrong-path). flush_i with load_use: flush wins, no bubble counted, stall_o = 0.
- hold_i with load_use: hold wins, counter unchanged. Bubble is inserted on the first edge hold_i drops if load_use still true.

Decomposition:
- Shared package mips_pkg: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10; ctrl bit index constants (CTRL_REG_WRITE=7 ... CTRL_JUMP=0); FUNCT_ADD=6'b100000, FUNCT_SUB=6'b100010, FUNCT_AND=6'b100100, FUNCT_OR=6'b100101, FUNCT_SLT=6'b101010.
- One sub-module: load_use_detect, purely combinational load_use equation; register and priority logic stay in id_ex_stage.

Test Plan:
- Reset: rst=1 mid-operation with ex_valid=1 -> all ex_* = 0, bubble_cnt=0 immediately, no clock needed.
- Plain load: id_valid=1, id_alu_op=2'b10, id_imm=32'h0000_002A, id_rd1=5, id_rd2=7 -> next edge ex_alu_op=2'b10, ex_funct=6'b101010, ex_rd1=5, ex_rd2=7, stall_o=0.
- Load-use: EX holds lw (mem_read=1, ex_rt=8); ID add with id_rs=8, id_uses_rs=1 -> stall_o=1 for one cycle, ex_valid=0 bubble, bubble_cnt=1; next edge add loads, stall_o=0.
- No hazard on $0: EX lw ex_rt=0, ID id_rs=0 -> stall_o=0, no bubble, bubble_cnt unchanged.
- Flush priority: flush_i=1 with load_use=1 -> stall_o=0, ex_valid=0, ex_ctrl=0, bubble_cnt unchanged.
- Hold then saturation: hold_i=1 for 3 cycles -> ex_* frozen, stall_o=1; preload counter near max, 3 more bubbles -> bubble_cnt stays 16'hFFFF.
